decode_scoreboard: RTL

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

---
 rtl/decode_scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/decode_scoreboard.sv
// Register scoreboard for an in-order decode stage: tracks pending writes per
// architectural register, detects RAW/WAW/capacity hazards and sequences flush/drain.
module decode_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  rs1_unreg,
    input  logic [4:0]  rs2_unreg,
    input  logic        rs1_read_unreg,
    input  logic        rs2_read_unreg,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_write,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    input  logic        drain_req,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] busy_mask,
    output logic [2:0]  inflight_count,
    output logic        drain_done,
    output logic        sb_error
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    state_e      state_q;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        done_q;
    logic        err_q;

    logic [31:0] clr, eff, set;
    logic        retire, wb_bad, rd_ok, raw, waw, cap;
    logic [2:0]  cnt_after;

    // A writeback only retires an entry if its bit is really pending; a stray
    // writeback is flagged and otherwise has no effect on mask or count.
    always_comb begin
        clr       = (wb_valid && wb_rd != 5'd0) ? (32'd1 << wb_rd) : 32'd0;
        eff       = busy_q & ~clr;
        retire    = |(clr & busy_q);
        wb_bad    = (clr != 32'd0) && !retire;
        rd_ok     = issue_rd_write && (issue_rd != 5'd0);
        raw       = (rs1_read_unreg & eff[rs1_unreg]) | (rs2_read_unreg & eff[rs2_unreg]);
        waw       = rd_ok & eff[issue_rd];
        cnt_after = cnt_q - {2'b00, retire};
        cap       = rd_ok && (cnt_after == MAX_CNT);

        if (state_q == ST_RUN) begin
            stall = issue_valid & (raw | waw | cap);
        end else begin
            stall = issue_valid;
        end
        issue_fire = issue_valid & ~stall;

        set    = (issue_fire && rd_ok) ? (32'd1 << issue_rd) : 32'd0;
        busy_d = eff | set;
        cnt_d  = cnt_q + {2'b00, (set != 32'd0)} - {2'b00, retire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            busy_q  <= 32'd0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_FLUSH;
                busy_q  <= 32'd0;
                cnt_q   <= 3'd0;
            end else begin
                busy_q <= busy_d;
                cnt_q  <= cnt_d;
                if (wb_bad) begin
                    err_q <= 1'b1;
                end
                case (state_q)
                    ST_RUN: begin
                        if (drain_req) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                    ST_FLUSH: begin
                        state_q <= drain_req ? ST_DRAIN : ST_RUN;
                    end
                    ST_DRAIN: begin
                        if (cnt_q == 3'd0) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    assign busy_mask      = busy_q;
    assign inflight_count = cnt_q;
    assign drain_done     = done_q;
    assign sb_error       = err_q;

endmodule
